// File: rtl/fp_int_mul.sv
// fp_int_mul: sequential FP16 x signed-integer multiplier.
// Produces the operand set for the fixed-point accumulator stage: sign,
// raw biased exponent and an unsigned fixed-point mantissa product. The
// mantissa product is formed by shift-add, one weight-magnitude bit per cycle.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            request, sampled only while busy=0 (IDLE or DONE)
//   act_in           FP16 activation {sign, exp[4:0], mant[9:0]}
//   weight_in        signed two's-complement weight, WEIGHT_WIDTH bits
//   busy             high while the shift-add runs
//   done             one-cycle pulse, result outputs were just updated
//   sign_out         product sign (never set for a zero product)
//   exp_out          raw biased exponent
//   fixed_point_out  unsigned mantissa product, 10+WEIGHT_WIDTH bits
//   special_out      activation was Inf/NaN (exp field 31)
//
// Build option: define SUBNORMAL_EN for exact subnormal activations;
// otherwise subnormals flush to zero at capture.
module fp_int_mul #(
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                act_in,
  input  logic [WEIGHT_WIDTH-1:0]    weight_in,
  output logic                       busy,
  output logic                       done,
  output logic                       sign_out,
  output logic [4:0]                 exp_out,
  output logic [10+WEIGHT_WIDTH-1:0] fixed_point_out,
  output logic                       special_out
);

  localparam int FW = 10 + WEIGHT_WIDTH;
  localparam int CW = (WEIGHT_WIDTH > 2) ? $clog2(WEIGHT_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WEIGHT_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FW-1:0]           acc_q, acc_d;
  logic [FW-1:0]           mcand_q, mcand_d;
  logic [WEIGHT_WIDTH-1:0] mult_q, mult_d;
  logic                    sgn_q, sgn_d;
  logic [4:0]              e_q, e_d;
  logic                    spc_q, spc_d;
  logic                    sign_out_q, sign_out_d;
  logic [4:0]              exp_out_q, exp_out_d;
  logic [FW-1:0]           fp_out_q, fp_out_d;
  logic                    special_out_q, special_out_d;

  // Operand decode for capture
  logic [4:0]              exp_f;
  logic                    exp_nz;
  logic [10:0]             m_cap;
  logic [4:0]              e_cap;
  logic [WEIGHT_WIDTH-1:0] wmag;
  logic                    sgn_cap;

  assign exp_f  = act_in[14:10];
  assign exp_nz = |exp_f;

`ifdef SUBNORMAL_EN
  // Subnormals use hidden=0 with effective exponent 1 (exact IEEE scaling).
  assign m_cap = {exp_nz, act_in[9:0]};
  assign e_cap = exp_nz ? exp_f : 5'd1;
`else
  // Subnormals (and zero) flush: zero significand, exponent field kept as 0.
  assign m_cap = exp_nz ? {1'b1, act_in[9:0]} : 11'd0;
  assign e_cap = exp_f;
`endif

  // Most negative weight negates to 2^(W-1), still representable unsigned.
  assign wmag    = weight_in[WEIGHT_WIDTH-1] ? ((~weight_in) + WEIGHT_WIDTH'(1))
                                             : weight_in;
  assign sgn_cap = act_in[15] ^ weight_in[WEIGHT_WIDTH-1];

  logic [FW-1:0] acc_sum;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mult_d        = mult_q;
    sgn_d         = sgn_q;
    e_d           = e_q;
    spc_d         = spc_q;
    sign_out_d    = sign_out_q;
    exp_out_d     = exp_out_q;
    fp_out_d      = fp_out_q;
    special_out_d = special_out_q;
    acc_sum       = acc_q + (mult_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_MUL;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = {{(WEIGHT_WIDTH-1){1'b0}}, m_cap};
          mult_d  = wmag;
          sgn_d   = sgn_cap;
          e_d     = e_cap;
          spc_d   = (exp_f == 5'd31);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        // LSB-first: multiplicand shifts left as the weight shifts right.
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d       = S_DONE;
          fp_out_d      = acc_sum;
          exp_out_d     = e_q;
          special_out_d = spc_q;
          // A zero product never carries a negative sign downstream.
          sign_out_d    = sgn_q & (|acc_sum);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mult_q        <= '0;
      sgn_q         <= 1'b0;
      e_q           <= '0;
      spc_q         <= 1'b0;
      sign_out_q    <= 1'b0;
      exp_out_q     <= '0;
      fp_out_q      <= '0;
      special_out_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mult_q        <= mult_d;
      sgn_q         <= sgn_d;
      e_q           <= e_d;
      spc_q         <= spc_d;
      sign_out_q    <= sign_out_d;
      exp_out_q     <= exp_out_d;
      fp_out_q      <= fp_out_d;
      special_out_q <= special_out_d;
    end
  end

  assign busy            = (state_q == S_MUL);
  assign done            = (state_q == S_DONE);
  assign sign_out        = sign_out_q;
  assign exp_out         = exp_out_q;
  assign fixed_point_out = fp_out_q;
  assign special_out     = special_out_q;

endmodule
